// File: rtl/latch_writer_pkg.sv
// Shared definitions for the latch bank writer: FSM state encoding,
// default parameter values and the address-to-strobe decode helper.
// Optional shadow copy of written values is enabled by LATCH_WRITER_SHADOW_EN.
package latch_writer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_NUM_LATCH  = 8;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  // Widest latch bank the decode helper can address.
  localparam int MAX_LATCH = 256;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Active-low one-hot of addr; all ones when addr is not below n.
  function automatic logic [MAX_LATCH-1:0] crit_onehot_n(input logic [31:0] addr,
                                                         input int n);
    logic [MAX_LATCH-1:0] one;
    one = {{(MAX_LATCH-1){1'b0}}, 1'b1};
    if (addr < 32'(n)) begin
      return ~(one << addr);
    end
    return '1;
  endfunction

endpackage

// File: rtl/latch_bank_writer_if.sv
// Write request channel into the latch bank writer.
// Handshake: the master raises wrValid with wrAddr/wrData stable; the
// transfer happens on a rising clk edge where wrValid && wrReady. The
// master must hold its request until that edge; wrReady never depends
// on wrValid.
interface latch_bank_writer_if #(
  parameter int AW     = 3,
  parameter int DATA_W = 8
);
  logic              wrValid;
  logic              wrReady;
  logic [AW-1:0]     wrAddr;
  logic [DATA_W-1:0] wrData;

  modport master (output wrValid, output wrAddr, output wrData, input wrReady);
  modport slave  (input wrValid, input wrAddr, input wrData, output wrReady);
endinterface

// File: rtl/latch_writer_phase_ctr.sv
// Loadable down-counter timing one phase of the write sequence.
// tc is high while the count is zero, i.e. in the last cycle of a phase.
module latch_writer_phase_ctr #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/latch_bank_writer.sv
// Write-side sequencer for a bank of transparent-low latches. Each accepted
// write drives the shared data bus, waits SETUP_CYC, pulls one crit strobe
// low for STROBE_CYC, then holds data for HOLD_CYC before going idle.
// Optional feature macro: LATCH_WRITER_SHADOW_EN adds a readable shadow copy
// of every completed write (ports shadowAddr / shadowData).
module latch_bank_writer
  import latch_writer_pkg::*;
#(
  parameter int NUM_LATCH  = DEF_NUM_LATCH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  localparam int AW = (NUM_LATCH > 2) ? $clog2(NUM_LATCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  latch_bank_writer_if.slave   wr,
  output logic [DATA_W-1:0]    latchData,
  output logic [NUM_LATCH-1:0] latchCrit,
  output logic                 busy,
  output logic                 addrErr,
  output state_t               dbg_state
`ifdef LATCH_WRITER_SHADOW_EN
  ,
  input  logic [AW-1:0]        shadowAddr,
  output logic [DATA_W-1:0]    shadowData
`endif
);

  localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Reject configurations the sequence cannot honour.
  if (NUM_LATCH < 2 || NUM_LATCH > MAX_LATCH) begin : g_bad_num_latch
    $error("latch_bank_writer: NUM_LATCH out of range");
  end
  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
    $error("latch_bank_writer: phase lengths must be at least 1");
  end

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_LATCH-1:0]  crit_q, crit_d;
  logic                  addr_err_q, addr_err_d;
  logic                  ctr_load, ctr_dec, ctr_tc;
  logic [CW-1:0]         ctr_val;
  logic                  handshake;

  assign wr.wrReady = (state_q == IDLE) && !rst;
  assign handshake  = wr.wrValid && wr.wrReady;

  latch_writer_phase_ctr #(.CW(CW)) u_phase_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (ctr_val),
    .tc       (ctr_tc)
  );

  // Sequence FSM: each phase loads the counter for the next phase on its tc.
  // crit is derived from the next state so the strobe is a clean flop output.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    addr_err_d = 1'b0;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    ctr_val    = '0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d    = SETUP;
          addr_d     = wr.wrAddr;
          data_d     = wr.wrData;
          addr_err_d = (32'(wr.wrAddr) >= 32'(NUM_LATCH));
          ctr_load   = 1'b1;
          ctr_val    = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (ctr_tc) begin
          state_d  = STROBE;
          ctr_load = 1'b1;
          ctr_val  = CW'(STROBE_CYC - 1);
        end else begin
          ctr_dec = 1'b1;
        end
      end
      STROBE: begin
        if (ctr_tc) begin
          state_d  = HOLD;
          ctr_load = 1'b1;
          ctr_val  = CW'(HOLD_CYC - 1);
        end else begin
          ctr_dec = 1'b1;
        end
      end
      HOLD: begin
        if (ctr_tc) begin
          state_d = IDLE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    crit_d = (state_d == STROBE) ? NUM_LATCH'(crit_onehot_n(32'(addr_q), NUM_LATCH))
                                 : '1;
  end

  // State and output registers; reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      crit_q     <= '1;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      crit_q     <= crit_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign latchData = data_q;
  assign latchCrit = crit_q;
  assign busy      = (state_q != IDLE);
  assign addrErr   = addr_err_q;
  assign dbg_state = state_q;

`ifdef LATCH_WRITER_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [NUM_LATCH];
  logic [DATA_W-1:0] shadow_d [NUM_LATCH];

  // Record the value on the edge that enters HOLD (strobe complete).
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == STROBE && state_d == HOLD && (32'(addr_q) < 32'(NUM_LATCH))) begin
      shadow_d[addr_q] = data_q;
    end
  end

  // Shadow storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadowData = (32'(shadowAddr) < 32'(NUM_LATCH)) ? shadow_q[shadowAddr] : '0;
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench for latch_bank_writer: defaults, a 6-latch bank and a
// 3/1/2 phase configuration; shadow checks when LATCH_WRITER_SHADOW_EN is set.
module tb_latch_bank_writer;
  import latch_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  latch_bank_writer_if #(.AW(3), .DATA_W(8)) wr_a ();
  latch_bank_writer_if #(.AW(3), .DATA_W(8)) wr_b ();
  latch_bank_writer_if #(.AW(3), .DATA_W(8)) wr_c ();

  logic [7:0] a_data, b_data, c_data;
  logic [7:0] a_crit, c_crit;
  logic [5:0] b_crit;
  logic       a_busy, b_busy, c_busy;
  logic       a_err, b_err, c_err;
  state_t     a_state, b_state, c_state;
`ifdef LATCH_WRITER_SHADOW_EN
  logic [2:0] a_sh_addr = 3'd0, b_sh_addr = 3'd0, c_sh_addr = 3'd0;
  logic [7:0] a_sh_data, b_sh_data, c_sh_data;
`endif

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  latch_bank_writer dut_a (
    .clk(clk), .rst(rst), .wr(wr_a),
    .latchData(a_data), .latchCrit(a_crit), .busy(a_busy),
    .addrErr(a_err), .dbg_state(a_state)
`ifdef LATCH_WRITER_SHADOW_EN
    , .shadowAddr(a_sh_addr), .shadowData(a_sh_data)
`endif
  );

  latch_bank_writer #(.NUM_LATCH(6)) dut_b (
    .clk(clk), .rst(rst), .wr(wr_b),
    .latchData(b_data), .latchCrit(b_crit), .busy(b_busy),
    .addrErr(b_err), .dbg_state(b_state)
`ifdef LATCH_WRITER_SHADOW_EN
    , .shadowAddr(b_sh_addr), .shadowData(b_sh_data)
`endif
  );

  latch_bank_writer #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_c (
    .clk(clk), .rst(rst), .wr(wr_c),
    .latchData(c_data), .latchCrit(c_crit), .busy(c_busy),
    .addrErr(c_err), .dbg_state(c_state)
`ifdef LATCH_WRITER_SHADOW_EN
    , .shadowAddr(c_sh_addr), .shadowData(c_sh_data)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    wr_a.wrValid = 1'b0; wr_a.wrAddr = '0; wr_a.wrData = '0;
    wr_b.wrValid = 1'b0; wr_b.wrAddr = '0; wr_b.wrData = '0;
    wr_c.wrValid = 1'b0; wr_c.wrAddr = '0; wr_c.wrData = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_crit !== 8'hFF) begin n_fail++; $display("FAIL reset_crit: got %h want ff", a_crit); end
    n_checks++;
    if (a_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", a_data); end
    n_checks++;
    if (a_busy !== 1'b0 || a_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0 0", a_busy, a_err);
    end
    n_checks++;
    if (wr_a.wrReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", wr_a.wrReady); end
    n_checks++;
    if (b_crit !== 6'h3F || c_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_other_duts: got b_crit=%h c_busy=%b want 3f 0", b_crit, c_busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr_a.wrReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b want 1", wr_a.wrReady); end
  endtask

  task automatic test_single_write();
    logic [7:0] exp_crit [5];
    exp_crit = '{8'hFF, 8'hF7, 8'hF7, 8'hFF, 8'hFF};
    @(negedge clk);
    wr_a.wrValid = 1'b1; wr_a.wrAddr = 3'd3; wr_a.wrData = 8'hA5;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) wr_a.wrValid = 1'b0;
      n_checks++;
      if (a_crit !== exp_crit[c-1] || a_data !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_write cycle %0d: got crit=%h data=%h want crit=%h data=a5",
                 c, a_crit, a_data, exp_crit[c-1]);
      end
      n_checks++;
      if (a_busy !== (c <= 4) || wr_a.wrReady !== (c == 5)) begin
        n_fail++;
        $display("FAIL single_write_flags cycle %0d: got busy=%b ready=%b want %b %b",
                 c, a_busy, wr_a.wrReady, (c <= 4), (c == 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_crit [10];
    logic [7:0] exp_data;
    exp_crit = '{8'hFF, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'hFF, 8'hFF};
    @(negedge clk);
    wr_a.wrValid = 1'b1; wr_a.wrAddr = 3'd0; wr_a.wrData = 8'h11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin wr_a.wrAddr = 3'd7; wr_a.wrData = 8'h22; end
      if (c == 6) wr_a.wrValid = 1'b0;
      exp_data = (c <= 5) ? 8'h11 : 8'h22;
      n_checks++;
      if (a_crit !== exp_crit[c-1] || a_data !== exp_data) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got crit=%h data=%h want crit=%h data=%h",
                 c, a_crit, a_data, exp_crit[c-1], exp_data);
      end
      n_checks++;
      if (wr_a.wrReady !== (c == 5 || c == 10)) begin
        n_fail++;
        $display("FAIL back_to_back_ready cycle %0d: got %b want %b", c, wr_a.wrReady, (c == 5 || c == 10));
      end
    end
  endtask

  task automatic test_addr_err();
    int pulses = 0;
    @(negedge clk);
    wr_b.wrValid = 1'b1; wr_b.wrAddr = 3'd7; wr_b.wrData = 8'h5A;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) wr_b.wrValid = 1'b0;
      if (b_err === 1'b1) pulses++;
      n_checks++;
      if (b_err !== (c == 1) || b_crit !== 6'h3F) begin
        n_fail++;
        $display("FAIL addr_err cycle %0d: got err=%b crit=%h want err=%b crit=3f", c, b_err, b_crit, (c == 1));
      end
      n_checks++;
      if (b_busy !== (c <= 4) || wr_b.wrReady !== (c == 5)) begin
        n_fail++;
        $display("FAIL addr_err_seq cycle %0d: got busy=%b ready=%b want %b %b",
                 c, b_busy, wr_b.wrReady, (c <= 4), (c == 5));
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL addr_err_count: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_a.wrValid = 1'b1; wr_a.wrAddr = 3'd2; wr_a.wrData = 8'h77;
    @(negedge clk);
    wr_a.wrValid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_crit !== 8'hFB || a_state !== STROBE) begin
      n_fail++; $display("FAIL reset_mid_strobe: got crit=%h state=%0d want fb %0d", a_crit, a_state, STROBE);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_crit !== 8'hFF || a_data !== 8'h00 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got crit=%h data=%h busy=%b want ff 00 0", a_crit, a_data, a_busy);
    end
    n_checks++;
    if (wr_a.wrReady !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ready_low: got %b want 0", wr_a.wrReady); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr_a.wrReady !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready_high: got %b want 1", wr_a.wrReady); end
  endtask

  task automatic test_phase_lengths();
    state_t exp_state [7];
    exp_state = '{SETUP, SETUP, SETUP, STROBE, HOLD, HOLD, IDLE};
    @(negedge clk);
    wr_c.wrValid = 1'b1; wr_c.wrAddr = 3'd1; wr_c.wrData = 8'hC3;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) wr_c.wrValid = 1'b0;
      n_checks++;
      if (c_crit !== ((c == 4) ? 8'hFD : 8'hFF) || c_data !== 8'hC3) begin
        n_fail++;
        $display("FAIL phase_len cycle %0d: got crit=%h data=%h want crit=%h data=c3",
                 c, c_crit, c_data, ((c == 4) ? 8'hFD : 8'hFF));
      end
      n_checks++;
      if (c_state !== exp_state[c-1] || c_busy !== (c <= 6) || wr_c.wrReady !== (c == 7)) begin
        n_fail++;
        $display("FAIL phase_len_state cycle %0d: got state=%0d busy=%b ready=%b want %0d %b %b",
                 c, c_state, c_busy, wr_c.wrReady, exp_state[c-1], (c <= 6), (c == 7));
      end
    end
  endtask

`ifdef LATCH_WRITER_SHADOW_EN
  task automatic test_shadow();
    @(negedge clk);
    wr_a.wrValid = 1'b1; wr_a.wrAddr = 3'd5; wr_a.wrData = 8'h3C;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) wr_a.wrValid = 1'b0;
      a_sh_addr = 3'd5;
      #1;
      n_checks++;
      if (a_sh_data !== ((c >= 4) ? 8'h3C : 8'h00)) begin
        n_fail++;
        $display("FAIL shadow_addr5 cycle %0d: got %h want %h", c, a_sh_data, ((c >= 4) ? 8'h3C : 8'h00));
      end
      a_sh_addr = 3'd6;
      #1;
      n_checks++;
      if (a_sh_data !== 8'h00) begin n_fail++; $display("FAIL shadow_addr6 cycle %0d: got %h want 00", c, a_sh_data); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_addr_err();
    test_reset_mid();
    test_phase_lengths();
`ifdef LATCH_WRITER_SHADOW_EN
    test_shadow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
